// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS subset: opcodes, functs, ALU
// control encodings, decoder control bundle, memory depths and GPIO address.
package mips_pkg;

   localparam int IMEM_DEPTH = 128;
   localparam int DMEM_DEPTH = 64;

   localparam logic [31:0] GPIO_ADDR = 32'h0000_0800;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD,
      ALUOP_SUB,
      ALUOP_FUNCT
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    reg_dst;
      logic    alu_src;
      logic    mem_to_reg;
      logic    mem_write;
      logic    branch;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/mips_rf_if.sv
// Register-file access bundle: two read ports and one write port.
interface mips_rf_if;

   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;

   modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
   modport slave  (input ra1, ra2, we, wa, wd, output rd1, rd2);

endinterface

// File: rtl/mips_imem.sv
// Instruction ROM, 128 words, combinational read; the image is written into
// mem through the hierarchy by the environment before reset deasserts.
module mips_imem
   import mips_pkg::*;
(
   input  logic [6:0]  a,
   output logic [31:0] rd
);

   logic [31:0] mem [IMEM_DEPTH];

   assign rd = mem[a];

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file, two combinational reads, one write on the rising edge.
// r0 is hard-wired to zero.
module mips_regfile (
   input logic     clk,
   mips_rf_if.slave rf
);

   logic [31:0] regs [0:31];

   // NOTE: the array has no reset; contents must survive reset and a reset
   // loop over 32 words would block RAM mapping.
   always_ff @(posedge clk) begin
      if (rf.we && (rf.wa != 5'd0)) regs[rf.wa] <= rf.wd;
   end

   assign rf.rd1 = (rf.ra1 == 5'd0) ? 32'd0 : regs[rf.ra1];
   assign rf.rd2 = (rf.ra2 == 5'd0) ? 32'd0 : regs[rf.ra2];

endmodule

// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS subset system: core, imem, dmem and one 8-bit input.
// Define MIPS_GPIO_EN to map gpi1 at address 0x800 for lw.
module mips_single_cycle_top
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic       memwrite,
   input  logic [7:0] gpi1
);

   logic [31:0] pc, pc_plus4, pc_branch, pc_next;
   logic [31:0] instr, simm, src_b, alu_result, read_data, wb_data;
   logic [5:0]  op, funct;
   logic        zero, gpio_sel, unused_bits;
   ctrl_t       ctrl;
   alu_ctrl_e   alu_ctrl;
   logic [31:0] dmem [DMEM_DEPTH];

   mips_imem imem (
      .a  (pc[8:2]),
      .rd (instr)
   );

   assign op          = instr[31:26];
   assign funct       = instr[5:0];
   assign simm        = {{16{instr[15]}}, instr[15:0]};
   assign unused_bits = ^instr[10:6];

   // NOTE: every field gets a default first so no path through the case
   // leaves a control bit unassigned and infers a latch.
   always_comb begin
      ctrl = '{reg_write: 1'b0, reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
               mem_write: 1'b0, branch: 1'b0, jump: 1'b0, alu_op: ALUOP_ADD};
      case (op)
         OP_RTYPE: begin
            if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = 1'b1;
               ctrl.alu_op    = ALUOP_FUNCT;
            end
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
         end
         OP_ADDI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_J:    ctrl.jump = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (ctrl.alu_op)
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   mips_rf_if rf ();

   assign rf.ra1 = instr[25:21];
   assign rf.ra2 = instr[20:16];
   assign rf.wa  = ctrl.reg_dst ? instr[15:11] : instr[20:16];
   assign rf.wd  = wb_data;
   assign rf.we  = ctrl.reg_write && reset;

   mips_regfile u_regfile (
      .clk (clk),
      .rf  (rf.slave)
   );

   assign src_b = ctrl.alu_src ? simm : rf.rd2;

   always_comb begin
      alu_result = 32'd0;
      case (alu_ctrl)
         ALU_AND: alu_result = rf.rd1 & src_b;
         ALU_OR:  alu_result = rf.rd1 | src_b;
         ALU_ADD: alu_result = rf.rd1 + src_b;
         ALU_SUB: alu_result = rf.rd1 - src_b;
         ALU_SLT: alu_result = ($signed(rf.rd1) < $signed(src_b)) ? 32'd1 : 32'd0;
         default: alu_result = 32'd0;
      endcase
   end

   assign zero = (alu_result == 32'd0);

`ifdef MIPS_GPIO_EN
   assign gpio_sel = (alu_result == GPIO_ADDR);
`else
   assign gpio_sel = 1'b0;
`endif

   assign read_data = gpio_sel ? {24'd0, gpi1} : dmem[alu_result[7:2]];
   assign wb_data   = ctrl.mem_to_reg ? read_data : alu_result;
   assign memwrite  = ctrl.mem_write && reset;

   // The GPIO address swallows the store; memwrite itself still reflects sw.
   always_ff @(posedge clk) begin
      if (memwrite && !gpio_sel) dmem[alu_result[7:2]] <= rf.rd2;
   end

   assign pc_plus4  = pc + 32'd4;
   assign pc_branch = pc_plus4 + {simm[29:0], 2'b00};

   always_comb begin
      pc_next = pc_plus4;
      if (ctrl.jump)             pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (ctrl.branch && zero) pc_next = pc_branch;
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values, matching the hardware.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= 32'd0;
      else        pc <= pc_next;
   end

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Self-checking bench for mips_single_cycle_top: loads a program through the
// imem hierarchy, scoreboards the PC trace and final architectural state.
module tb_mips_single_cycle_top;

   logic       clk;
   logic       reset;
   logic       memwrite;
   logic [7:0] gpi1;

   int total = 0;
   int bad   = 0;

   mips_single_cycle_top dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .gpi1     (gpi1)
   );

   // Standalone register file driven through the interface for r0 checks.
   mips_rf_if rf_bus ();

   mips_regfile u_rf_unit (
      .clk (clk),
      .rf  (rf_bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic [6:0] a;
      logic       mw;
   } trace_t;

   typedef struct {
      string       tag;
      bit          is_mem;
      int          idx;
      logic [31:0] exp;
   } state_t;

   trace_t trace_q[$];
   state_t state_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   function automatic logic [31:0] read_state(input bit is_mem, input int idx);
      if (is_mem) return dut.dmem[idx];
      return dut.u_regfile.regs[idx];
   endfunction

   task automatic push_state(input string tag, input bit is_mem, input int idx,
                             input logic [31:0] exp);
      state_t s;
      s.tag = tag; s.is_mem = is_mem; s.idx = idx; s.exp = exp;
      state_q.push_back(s);
   endtask

   task automatic load_program();
      logic [31:0] prog [0:127];
      trace_t t;
      for (int i = 0; i < 128; i++) prog[i] = 32'd0;
      prog[0]  = enc_i(6'h08, 5'd2, 5'd0, 16'd5);        // addi $2,$0,5
      prog[1]  = enc_i(6'h08, 5'd3, 5'd0, 16'd12);       // addi $3,$0,12
      prog[2]  = enc_r(5'd4, 5'd2, 5'd3, 6'h20);         // add  $4,$2,$3
      prog[3]  = enc_r(5'd5, 5'd3, 5'd2, 6'h22);         // sub  $5,$3,$2
      prog[4]  = enc_r(5'd6, 5'd2, 5'd3, 6'h2A);         // slt  $6,$2,$3
      prog[5]  = enc_i(6'h2B, 5'd4, 5'd0, 16'd84);       // sw   $4,84($0)
      prog[6]  = enc_i(6'h23, 5'd7, 5'd0, 16'd84);       // lw   $7,84($0)
      prog[7]  = enc_i(6'h04, 5'd2, 5'd2, 16'd2);        // beq  $2,$2,+2
      prog[8]  = enc_i(6'h08, 5'd10, 5'd0, 16'd99);
      prog[9]  = enc_i(6'h08, 5'd10, 5'd0, 16'd99);
      prog[10] = enc_i(6'h04, 5'd3, 5'd2, 16'd5);        // beq  $2,$3,+5 (not taken)
      prog[11] = enc_i(6'h2B, 5'd3, 5'd0, 16'd0);        // sw   $3,0($0)
      prog[12] = enc_i(6'h23, 5'd8, 5'd0, 16'h0800);     // lw   $8,0x800($0)
      prog[13] = enc_i(6'h08, 5'd9, 5'd0, 16'd3);        // addi $9,$0,3
      prog[14] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);        // addi $0,$0,7
      prog[15] = enc_r(5'd9, 5'd0, 5'd0, 6'h20);         // add  $9,$0,$0
      prog[16] = enc_i(6'h08, 5'd12, 5'd0, 16'hFFFF);    // addi $12,$0,-1
      prog[17] = enc_r(5'd13, 5'd12, 5'd2, 6'h2A);       // slt  $13,$12,$2
      prog[18] = enc_r(5'd14, 5'd2, 5'd3, 6'h24);        // and  $14,$2,$3
      prog[19] = enc_r(5'd15, 5'd2, 5'd3, 6'h25);        // or   $15,$2,$3
      prog[20] = enc_j(26'h3F);
      prog[63] = enc_j(26'h3F);
      for (int i = 0; i < 128; i++) dut.imem.mem[i] = prog[i];

      for (int w = 1; w <= 20; w++) begin
         if (w == 8 || w == 9) continue;
         t.a = 7'(w); t.mw = (w == 5 || w == 11);
         trace_q.push_back(t);
      end
      for (int k = 0; k < 4; k++) begin
         t.a = 7'h3F; t.mw = 1'b0;
         trace_q.push_back(t);
      end

      push_state("r2_addi",  1'b0, 2,  32'd5);
      push_state("r3_addi",  1'b0, 3,  32'd12);
      push_state("r4_add",   1'b0, 4,  32'd17);
      push_state("r5_sub",   1'b0, 5,  32'd7);
      push_state("r6_slt",   1'b0, 6,  32'd1);
      push_state("dmem21",   1'b1, 21, 32'd17);
      push_state("r7_lw",    1'b0, 7,  32'd17);
      push_state("dmem0",    1'b1, 0,  32'd12);
`ifdef MIPS_GPIO_EN
      push_state("r8_gpio",  1'b0, 8,  32'h0000_00A5);
`else
      push_state("r8_gpio",  1'b0, 8,  32'd12);
`endif
      push_state("r9_zero",  1'b0, 9,  32'd0);
      push_state("r12_neg",  1'b0, 12, 32'hFFFF_FFFF);
      push_state("r13_slts", 1'b0, 13, 32'd1);
      push_state("r14_and",  1'b0, 14, 32'd4);
      push_state("r15_or",   1'b0, 15, 32'd13);
   endtask

   initial begin
      trace_t t;
      state_t s;
      int     n;
      reset       = 1'b0;
      gpi1        = 8'hA5;
      rf_bus.ra1  = 5'd0;
      rf_bus.ra2  = 5'd0;
      rf_bus.we   = 1'b0;
      rf_bus.wa   = 5'd0;
      rf_bus.wd   = 32'd0;

      #1 load_program();
      #1;
      check("rst_imem_a", 32'(dut.imem.a), 32'd0);
      check("rst_memwrite", 32'(memwrite), 32'd0);
      #3 reset = 1'b1;

      n = 0;
      while (trace_q.size() > 0) begin
         @(posedge clk);
         #1;
         t = trace_q.pop_front();
         n++;
         check($sformatf("imem_a_c%0d", n), 32'(dut.imem.a), 32'(t.a));
         check($sformatf("memwrite_c%0d", n), 32'(memwrite), 32'(t.mw));
      end

      while (state_q.size() > 0) begin
         s = state_q.pop_front();
         check(s.tag, read_state(s.is_mem, s.idx), s.exp);
      end

      // Mid-program reset: PC clears at once and the next edge runs word 0.
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("midrst_imem_a", 32'(dut.imem.a), 32'd0);
      check("midrst_memwrite", 32'(memwrite), 32'd0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_resume", 32'(dut.imem.a), 32'd1);
      check("midrst_r4_kept", dut.u_regfile.regs[4], 32'd17);

      // Register file unit: r0 discards writes, other registers hold them.
      rf_bus.we = 1'b1; rf_bus.wa = 5'd0; rf_bus.wd = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      rf_bus.wa = 5'd5; rf_bus.wd = 32'h1234_5678;
      @(posedge clk);
      #1;
      rf_bus.we = 1'b0; rf_bus.ra1 = 5'd0; rf_bus.ra2 = 5'd5;
      #1;
      check("rf_r0", rf_bus.rd1, 32'd0);
      check("rf_r5", rf_bus.rd2, 32'h1234_5678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
